tdm_demux2: RTL and testbench

Receive-side counterpart of the 2:1 selector: recovers two channels from one time-division-multiplexed serial line. The transmit side drives channel 0 and channel 1 bits alternately onto the line, with a one-cycle frame sync. The block hunts for sync, then samples each slot at a programmable point. It rebuilds one WORD_W-bit word per channel and presents both words with a one-cycle valid strobe per frame. It sits at the far end of the shared line, before any per-channel logic.

---
 rtl/tdm_pkg.sv | 14 +
 rtl/tdm_slot_timer.sv | 49 ++++
 rtl/tdm_demux2.sv | 109 ++++++++++
 tb/tb_tdm_demux2.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared types and helpers for the two-channel TDM receiver.
// Holds the FSM state encoding and the counter-width helper.
package tdm_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int clog2w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tdm_slot_timer.sv
// Cycle-within-slot and slot-within-frame counters for the TDM receiver.
// The start cycle is treated as cycle 0 of slot 0 combinationally.
module tdm_slot_timer
    import tdm_pkg::*;
#(
    parameter int WORD_W      = 4,
    parameter int SLOT_CYCLES = 4,
    parameter int SAMPLE_AT   = 2,
    localparam int SW = clog2w(2 * WORD_W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          run,
    output logic          sample,
    output logic [SW-1:0] slot,
    output logic          frame_end
);

    localparam int CW = clog2w(SLOT_CYCLES);
    localparam logic [CW-1:0] CLAST = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0] CSAMP = CW'(SAMPLE_AT);
    localparam logic [SW-1:0] SLAST = SW'(2 * WORD_W - 1);

    logic [CW-1:0] cyc_q;
    logic [CW-1:0] cyc;
    logic [SW-1:0] slot_q;
    logic          active;

    assign active    = start | run;
    assign cyc       = start ? '0 : cyc_q;
    assign slot      = start ? '0 : slot_q;
    assign sample    = active && (cyc == CSAMP);
    assign frame_end = active && (cyc == CLAST) && (slot == SLAST);

    always_ff @(posedge clk) begin
        if (!rst_n || !active) begin
            cyc_q  <= '0;
            slot_q <= '0;
        end else if (cyc == CLAST) begin
            cyc_q  <= '0;
            slot_q <= (slot == SLAST) ? '0 : slot + 1'b1;
        end else begin
            cyc_q  <= cyc + 1'b1;
            slot_q <= slot;
        end
    end

endmodule

// File: rtl/tdm_demux2.sv
// Two-channel TDM receiver: hunts for frame sync, samples each slot once,
// and delivers both channel words with a one-cycle strobe per frame.
module tdm_demux2
    import tdm_pkg::*;
#(
    parameter int WORD_W      = 4,
    parameter int SLOT_CYCLES = 4,
    parameter int SAMPLE_AT   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              z,
    input  logic              sync,
    output logic [WORD_W-1:0] d0_word,
    output logic [WORD_W-1:0] d1_word,
    output logic              word_valid,
    output logic              locked,
    output logic              sync_err
);

    localparam int SW = clog2w(2 * WORD_W);

    if (SAMPLE_AT < 0 || SAMPLE_AT >= SLOT_CYCLES) begin : g_bad_sample
        $error("tdm_demux2: SAMPLE_AT must lie in 0..SLOT_CYCLES-1");
    end

    state_t            state_q, state_d;
    logic              start, run, resync;
    logic              sample, frame_end;
    logic [SW-1:0]     slot;
    logic [WORD_W-1:0] sh0_q, sh1_q, sh0_d, sh1_d;

    tdm_slot_timer #(
        .WORD_W      (WORD_W),
        .SLOT_CYCLES (SLOT_CYCLES),
        .SAMPLE_AT   (SAMPLE_AT)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .run       (run),
        .sample    (sample),
        .slot      (slot),
        .frame_end (frame_end)
    );

    // word_valid high in RUN marks the frame-boundary cycle
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        run     = 1'b0;
        resync  = 1'b0;
        unique case (state_q)
            HUNT: begin
                if (sync) begin
                    start   = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (sync) begin
                    start  = 1'b1;
                    resync = !word_valid;
                end else if (word_valid) begin
                    state_d = HUNT;
                end else begin
                    run = 1'b1;
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_comb begin
        sh0_d = start ? '0 : sh0_q;
        sh1_d = start ? '0 : sh1_q;
        for (int k = 0; k < WORD_W; k++) begin
            if (sample && slot == SW'(2 * k))
                sh0_d[k] = z;
            if (sample && slot == SW'(2 * k + 1))
                sh1_d[k] = z;
        end
    end

    assign locked = (state_q == RUN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= HUNT;
            sh0_q      <= '0;
            sh1_q      <= '0;
            d0_word    <= '0;
            d1_word    <= '0;
            word_valid <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh0_q      <= sh0_d;
            sh1_q      <= sh1_d;
            word_valid <= frame_end;
            sync_err   <= resync;
            if (frame_end) begin
                d0_word <= sh0_d;
                d1_word <= sh1_d;
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux2.sv
// Directed bench for tdm_demux2: default instance plus a one-cycle-slot instance.
// Scenario streams are built per cycle, outputs recorded, then checked from a table.
module tb_tdm_demux2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       z0, sync0, rstn0;
    logic       z1, sync1, rstn1;
    logic [3:0] d0a, d1a, d0b, d1b;
    logic       wva, lka, sea, wvb, lkb, seb;

    tdm_demux2 dut (
        .clk(clk), .rst_n(rstn0), .z(z0), .sync(sync0),
        .d0_word(d0a), .d1_word(d1a), .word_valid(wva),
        .locked(lka), .sync_err(sea)
    );

    tdm_demux2 #(.WORD_W(4), .SLOT_CYCLES(1), .SAMPLE_AT(0)) dut1 (
        .clk(clk), .rst_n(rstn1), .z(z1), .sync(sync1),
        .d0_word(d0b), .d1_word(d1b), .word_valid(wvb),
        .locked(lkb), .sync_err(seb)
    );

    localparam int MAXC = 200;

    logic       za [MAXC];
    logic       sa [MAXC];
    logic       ra [MAXC];
    logic       rwv [MAXC];
    logic       rlk [MAXC];
    logic       rse [MAXC];
    logic [3:0] rd0 [MAXC];
    logic [3:0] rd1 [MAXC];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         scen;
        int         cyc;
        logic       wv;
        logic [3:0] d0;
        logic [3:0] d1;
        logic       lk;
        logic       se;
    } chk_t;

    chk_t tbl [$];

    task automatic clear_stream();
        for (int i = 0; i < MAXC; i++) begin
            za[i] = 1'b0;
            sa[i] = 1'b0;
            ra[i] = 1'b1;
        end
    endtask

    task automatic put_frame(input int s, input int sc, input int samp,
                             input logic [3:0] a, input logic [3:0] b,
                             input bit glitch);
        logic bitv;
        sa[s] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bitv = (i % 2 == 0) ? a[i / 2] : b[i / 2];
            for (int c = 0; c < sc; c++)
                za[s + i * sc + c] = (glitch && c != samp) ? ~bitv : bitv;
        end
    endtask

    task automatic run_scen(input int sel, input int len);
        for (int t = 0; t < len; t++) begin
            @(negedge clk);
            if (sel == 0) begin
                rwv[t] = wva; rlk[t] = lka; rse[t] = sea;
                rd0[t] = d0a; rd1[t] = d1a;
                z0 = za[t]; sync0 = sa[t]; rstn0 = ra[t];
                z1 = 1'b0; sync1 = 1'b0; rstn1 = 1'b1;
            end else begin
                rwv[t] = wvb; rlk[t] = lkb; rse[t] = seb;
                rd0[t] = d0b; rd1[t] = d1b;
                z1 = za[t]; sync1 = sa[t]; rstn1 = ra[t];
                z0 = 1'b0; sync0 = 1'b0; rstn0 = 1'b1;
            end
        end
    endtask

    task automatic check_scen(input int scen, input int len,
                              input int exp_wv, input int exp_se);
        int nwv, nse;
        foreach (tbl[i]) begin
            if (tbl[i].scen == scen) begin
                chk_t e;
                int   c;
                e = tbl[i];
                c = e.cyc;
                checks++;
                if (rwv[c] !== e.wv || rd0[c] !== e.d0 || rd1[c] !== e.d1 ||
                    rlk[c] !== e.lk || rse[c] !== e.se) begin
                    errors++;
                    $display("FAIL s%0d cyc%0d: got wv=%b d0=%h d1=%h lk=%b se=%b, want wv=%b d0=%h d1=%h lk=%b se=%b",
                             scen, c, rwv[c], rd0[c], rd1[c], rlk[c], rse[c],
                             e.wv, e.d0, e.d1, e.lk, e.se);
                end
            end
        end
        nwv = 0;
        nse = 0;
        for (int t = 0; t < len; t++) begin
            if (rwv[t] === 1'b1) nwv++;
            if (rse[t] === 1'b1) nse++;
        end
        checks++;
        if (nwv != exp_wv) begin
            errors++;
            $display("FAIL s%0d strobe_count: got %0d want %0d", scen, nwv, exp_wv);
        end
        checks++;
        if (nse != exp_se) begin
            errors++;
            $display("FAIL s%0d sync_err_count: got %0d want %0d", scen, nse, exp_se);
        end
    endtask

    task automatic check_locked(input int scen, input int lo, input int hi,
                                input logic want);
        int bad;
        bad = 0;
        for (int t = lo; t <= hi; t++)
            if (rlk[t] !== want) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL s%0d locked_%0d_%0d: got %0d cycles off, want locked=%b throughout",
                     scen, lo, hi, bad, want);
        end
    endtask

    initial begin
        tbl.push_back('{1,  0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0});
        tbl.push_back('{1,  1, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0});
        tbl.push_back('{1, 31, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0});
        tbl.push_back('{1, 32, 1'b1, 4'hA, 4'h5, 1'b1, 1'b0});
        tbl.push_back('{1, 33, 1'b0, 4'hA, 4'h5, 1'b0, 1'b0});
        tbl.push_back('{1, 39, 1'b0, 4'hA, 4'h5, 1'b0, 1'b0});
        tbl.push_back('{2, 32, 1'b1, 4'hA, 4'h5, 1'b1, 1'b0});
        tbl.push_back('{2, 33, 1'b0, 4'hA, 4'h5, 1'b1, 1'b0});
        tbl.push_back('{2, 64, 1'b1, 4'h3, 4'hC, 1'b1, 1'b0});
        tbl.push_back('{2, 65, 1'b0, 4'h3, 4'hC, 1'b0, 1'b0});
        tbl.push_back('{3, 14, 1'b0, 4'h3, 4'hC, 1'b1, 1'b1});
        tbl.push_back('{3, 15, 1'b0, 4'h3, 4'hC, 1'b1, 1'b0});
        tbl.push_back('{3, 32, 1'b0, 4'h3, 4'hC, 1'b1, 1'b0});
        tbl.push_back('{3, 45, 1'b1, 4'hF, 4'h0, 1'b1, 1'b0});
        tbl.push_back('{3, 46, 1'b0, 4'hF, 4'h0, 1'b0, 1'b0});
        tbl.push_back('{4, 32, 1'b1, 4'hA, 4'h5, 1'b1, 1'b0});
        tbl.push_back('{5, 10, 1'b0, 4'hA, 4'h5, 1'b1, 1'b0});
        tbl.push_back('{5, 11, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0});
        tbl.push_back('{5, 32, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0});
        tbl.push_back('{6,  0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0});
        tbl.push_back('{6, 51, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0});
        tbl.push_back('{6, 58, 1'b1, 4'h6, 4'h9, 1'b1, 1'b0});
        tbl.push_back('{6, 59, 1'b0, 4'h6, 4'h9, 1'b0, 1'b0});

        z0 = 1'b0; sync0 = 1'b0; rstn0 = 1'b0;
        z1 = 1'b0; sync1 = 1'b0; rstn1 = 1'b0;
        repeat (3) @(negedge clk);
        rstn0 = 1'b1;
        rstn1 = 1'b1;

        clear_stream();
        put_frame(0, 4, 2, 4'hA, 4'h5, 1'b0);
        run_scen(0, 40);
        check_scen(1, 40, 1, 0);
        check_locked(1, 1, 32, 1'b1);

        clear_stream();
        put_frame(0, 4, 2, 4'hA, 4'h5, 1'b0);
        put_frame(32, 4, 2, 4'h3, 4'hC, 1'b0);
        run_scen(0, 72);
        check_scen(2, 72, 2, 0);
        check_locked(2, 1, 64, 1'b1);

        clear_stream();
        put_frame(0, 4, 2, 4'hA, 4'h5, 1'b0);
        put_frame(13, 4, 2, 4'hF, 4'h0, 1'b0);
        run_scen(0, 50);
        check_scen(3, 50, 1, 1);

        clear_stream();
        put_frame(0, 4, 2, 4'hA, 4'h5, 1'b1);
        run_scen(0, 40);
        check_scen(4, 40, 1, 0);

        clear_stream();
        put_frame(0, 4, 2, 4'hA, 4'h5, 1'b0);
        sa[10] = 1'b1;
        ra[10] = 1'b0;
        run_scen(0, 40);
        check_scen(5, 40, 0, 0);
        check_locked(5, 11, 39, 1'b0);

        clear_stream();
        for (int i = 0; i < 50; i++)
            za[i] = 1'($urandom_range(0, 1));
        put_frame(50, 1, 0, 4'h6, 4'h9, 1'b0);
        run_scen(1, 62);
        check_scen(6, 62, 1, 0);
        check_locked(6, 0, 50, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
